// File: rtl/select_scan_ctrl_pkg.sv
// Shared encodings for the mux select scanner: FSM state codes and settle-counter width.
package select_scan_ctrl_pkg;

   localparam logic [1:0] IdleEnc   = 2'd0;
   localparam logic [1:0] SettleEnc = 2'd1;
   localparam logic [1:0] SampleEnc = 2'd2;
   localparam logic [1:0] DoneEnc   = 2'd3;

   // Wide enough for SETTLE_CYCLES-1 up to 14.
   localparam int unsigned CntWidth = 4;

   typedef enum logic [1:0] {
      StIdle   = IdleEnc,
      StSettle = SettleEnc,
      StSample = SampleEnc,
      StDone   = DoneEnc
   } scan_state_e;

endpackage

// File: rtl/select_scan_ctrl_scan_settle_counter.sv
// Loadable down-counter that saturates at zero and flags when it gets there.
module select_scan_ctrl_scan_settle_counter
   import select_scan_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                clear_bar,
   input  logic                load,
   input  logic [CntWidth-1:0] load_value,
   input  logic                dec,
   output logic [CntWidth-1:0] count,
   output logic                zero
);

   logic [CntWidth-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - CntWidth'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!clear_bar) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/select_scan_ctrl.sv
// Walks a 74151-style mux through every data input, lets Y settle, and captures each bit into Q.
module select_scan_ctrl
   import select_scan_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH_IN      = 5,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned DELAY_RISE    = 0,
   parameter int unsigned DELAY_FALL    = 0,
   localparam int unsigned SelWidth     = (WIDTH_IN > 1) ? $clog2(WIDTH_IN) : 1
) (
   input  logic                Clk,
   input  logic                Clear_bar,
   input  logic                Start,
   input  logic                Y,
   output logic [SelWidth-1:0] Select,
   output logic                Enable_bar,
   output logic [WIDTH_IN-1:0] Q,
   output logic                Busy,
   output logic                Done
);

   localparam logic [SelWidth-1:0] SelLast    = SelWidth'(WIDTH_IN - 1);
   localparam logic [CntWidth-1:0] SettleLoad = CntWidth'(SETTLE_CYCLES - 1);

   scan_state_e         state_q, state_d;
   logic [SelWidth-1:0] sel_q, sel_d;
   logic [WIDTH_IN-1:0] q_q, q_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                en_bar_q, en_bar_d;
   logic                cnt_load, cnt_dec, cnt_zero;
   logic [CntWidth-1:0] cnt_value;

   select_scan_ctrl_scan_settle_counter u_settle (
      .clk        (Clk),
      .clear_bar  (Clear_bar),
      .load       (cnt_load),
      .load_value (SettleLoad),
      .dec        (cnt_dec),
      .count      (cnt_value),
      .zero       (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      q_d      = q_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (Start) begin
               state_d  = StSettle;
               sel_d    = '0;
               q_d      = '0;
               cnt_load = 1'b1;
            end
         end
         StSettle: begin
            if (cnt_zero) begin
               state_d = StSample;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         StSample: begin
            for (int unsigned i = 0; i < WIDTH_IN; i++) begin
               if (sel_q == SelWidth'(i)) begin
                  q_d[i] = Y;
               end
            end
            // Stop on the last real input so unused select codes are never driven.
            if (sel_q == SelLast) begin
               state_d = StDone;
            end else begin
               sel_d    = sel_q + SelWidth'(1);
               cnt_load = 1'b1;
               state_d  = StSettle;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output flags are registered from the next state so they change together with it.
   always_comb begin
      busy_d   = (state_d == StSettle) || (state_d == StSample);
      done_d   = (state_d == StDone);
      en_bar_d = !busy_d;
   end

   always_ff @(posedge Clk) begin
      if (!Clear_bar) begin
         state_q  <= StIdle;
         sel_q    <= '0;
         q_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         en_bar_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         q_q      <= q_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         en_bar_q <= en_bar_d;
      end
   end

   // Rise/fall delays are timing annotations only; the implemented outputs are the flops above.
   if ((DELAY_RISE > 0) || (DELAY_FALL > 0)) begin : g_delay_annotated
   end

   logic unused_cnt;
   assign unused_cnt = ^cnt_value;

   assign Select     = sel_q;
   assign Enable_bar = en_bar_q;
   assign Q          = q_q;
   assign Busy       = busy_q;
   assign Done       = done_q;

endmodule

// File: tb/tb_select_scan_ctrl.sv
// Scoreboard bench: select_scan_ctrl scanning a delayed ttl_74151 model; expected Q/Done edge queued per Start.
module tb_select_scan_ctrl;
   import select_scan_ctrl_pkg::*;

   localparam int W          = 5;
   localparam int SC         = 2;
   localparam int ScanEdges  = W * (SC + 1);

   typedef struct {
      logic [W-1:0] q;
      int           done_edge;
   } exp_t;

   logic         clk, clear_bar, start, y, en_bar, busy, done, mon_en;
   logic [W-1:0] d, q;
   logic [2:0]   sel;
   exp_t         sb_q[$];
   int           n_tests, n_fail, edge_cnt, done_seen, bc, n0, d1;

   select_scan_ctrl #(
      .WIDTH_IN      (W),
      .SETTLE_CYCLES (SC),
      .DELAY_RISE    (0),
      .DELAY_FALL    (0)
   ) dut (
      .Clk        (clk),
      .Clear_bar  (clear_bar),
      .Start      (start),
      .Y          (y),
      .Select     (sel),
      .Enable_bar (en_bar),
      .Q          (q),
      .Busy       (busy),
      .Done       (done)
   );

   ttl_74151 #(
      .WIDTH_IN   (W),
      .DELAY_RISE (3),
      .DELAY_FALL (2)
   ) u_mux (
      .D          (d),
      .Select     (sel),
      .Enable_bar (en_bar),
      .Y          (y)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   initial done_seen = 0;
   always @(negedge clk) begin
      if (mon_en) begin
         check_eq("sel_range", {31'd0, sel < 3'd5}, 1);
         check_eq("en_only_busy", {31'd0, en_bar | busy}, 1);
         if (done) begin
            done_seen <= done_seen + 1;
            if (sb_q.size() == 0) begin
               check_eq("done_spurious", {31'd0, done}, 0);
            end else begin
               check_eq("scan_q", {27'd0, q}, {27'd0, sb_q[0].q});
               check_eq("done_edge", edge_cnt, sb_q[0].done_edge);
               void'(sb_q.pop_front());
            end
         end
      end
   end

   task automatic start_scan(input logic [W-1:0] expq);
      start = 1'b1;
      sb_q.push_back('{expq, edge_cnt + 1 + ScanEdges});
   endtask

   task automatic wait_done(input string tag, input bit release_start, output int busy_cycles);
      bit seen;
      seen        = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (release_start) start = 1'b0;
         if (busy) busy_cycles++;
         if (done) seen = 1'b1;
      end
      if (!seen) check_eq({tag, "_timeout"}, 0, 1);
   endtask

   task automatic wait_sel(input string tag, input logic [2:0] v);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (sel == v) seen = 1'b1;
      end
      if (!seen) check_eq({tag, "_timeout"}, 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      mon_en    = 1'b0;
      clear_bar = 1'b0;
      start     = 1'b0;
      d         = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_sel", {29'd0, sel}, 0);
      check_eq("rst_en_bar", {31'd0, en_bar}, 1);
      check_eq("rst_q", {27'd0, q}, 0);
      check_eq("rst_busy", {31'd0, busy}, 0);
      check_eq("rst_done", {31'd0, done}, 0);
      clear_bar = 1'b1;
      mon_en    = 1'b1;
      @(negedge clk);

      // Single pulse scan
      d = 5'b01011;
      start_scan(d);
      wait_done("scan1", 1'b1, bc);
      check_eq("busy_cycles", bc, ScanEdges);
      @(negedge clk);
      check_eq("done_one_cycle", {31'd0, done}, 0);
      check_eq("en_bar_after", {31'd0, en_bar}, 1);
      check_eq("q_hold", {27'd0, q}, 32'b01011);
      // Clear_bar low between edges only
      #1 clear_bar = 1'b0;
      #2 clear_bar = 1'b1;
      @(negedge clk);
      check_eq("q_no_edge_clear", {27'd0, q}, 32'b01011);
      check_eq("sel_idle_hold", {29'd0, sel}, 4);

      // Start held high: back-to-back scans
      d = 5'b11110;
      start_scan(d);
      sb_q.push_back('{5'b11110, sb_q[sb_q.size()-1].done_edge + ScanEdges + 2});
      wait_done("b2b_1", 1'b0, bc);
      d1 = edge_cnt;
      wait_done("b2b_2", 1'b0, bc);
      start = 1'b0;
      check_eq("b2b_spacing", edge_cnt - d1, 17);
      repeat (2) @(negedge clk);

      // Start during scan is ignored
      d = 5'b10101;
      start_scan(d);
      @(negedge clk);
      start = 1'b0;
      wait_sel("ign_sel", 3'd2);
      start = 1'b1;
      n0 = done_seen;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignored", 1'b0, bc);
      repeat (25) @(negedge clk);
      check_eq("single_done", done_seen - n0, 1);

      // Reset mid-scan
      d = 5'b11111;
      start_scan(d);
      @(negedge clk);
      start = 1'b0;
      wait_sel("rst_mid_sel", 3'd3);
      check_eq("q_partial", {27'd0, q}, 32'b00111);
      clear_bar = 1'b0;
      sb_q.delete();
      n0 = done_seen;
      @(negedge clk);
      clear_bar = 1'b1;
      check_eq("mid_rst_sel", {29'd0, sel}, 0);
      check_eq("mid_rst_en_bar", {31'd0, en_bar}, 1);
      check_eq("mid_rst_q", {27'd0, q}, 0);
      check_eq("mid_rst_busy", {31'd0, busy}, 0);
      repeat (30) @(negedge clk);
      check_eq("no_done_after_rst", done_seen - n0, 0);

      // D changes after Select passes 2: per-bit sampling
      d = 5'b00000;
      start_scan(5'b11000);
      @(negedge clk);
      start = 1'b0;
      wait_sel("perbit_sel", 3'd3);
      d = 5'b11111;
      wait_done("perbit", 1'b0, bc);
      repeat (2) @(negedge clk);

      // Reset coincident with the final SAMPLE edge
      d = 5'b11111;
      start_scan(d);
      @(negedge clk);
      start = 1'b0;
      wait_sel("rst_smp_sel", 3'd4);
      repeat (2) @(negedge clk);
      clear_bar = 1'b0;
      sb_q.delete();
      n0 = done_seen;
      @(negedge clk);
      clear_bar = 1'b1;
      check_eq("smp_rst_done", {31'd0, done}, 0);
      check_eq("smp_rst_q", {27'd0, q}, 0);
      repeat (20) @(negedge clk);
      check_eq("no_done_smp_rst", done_seen - n0, 0);

      check_eq("sb_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// Behavioural 74151-style load with separate rise/fall propagation delay on Y.
module ttl_74151 #(
   parameter int WIDTH_IN   = 8,
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic [WIDTH_IN-1:0]         D,
   input  logic [$clog2(WIDTH_IN)-1:0] Select,
   input  logic                        Enable_bar,
   output logic                        Y
);

   logic y_raw;

   always_comb begin
      y_raw = 1'b0;
      for (int i = 0; i < WIDTH_IN; i++) begin
         if (!Enable_bar && (Select == i[$clog2(WIDTH_IN)-1:0])) y_raw = D[i];
      end
   end

   initial Y = 1'b0;
   always @(y_raw) begin
      if (y_raw) Y <= #(DELAY_RISE) 1'b1;
      else Y <= #(DELAY_FALL) 1'b0;
   end

endmodule
